// File: rtl/symbol_sync.sv
// symbol_sync: picks the oversampling phase with the largest |sample| energy over
// an N_ACC-symbol window and strobes o_sync once per symbol at that phase.
module symbol_sync #(
    parameter int OS     = 4,
    parameter int TAPS   = 6,
    parameter int S_COEF = 8,
    parameter int S_IN   = 2,
    parameter int S_OUT  = S_COEF + S_IN,
    parameter int N_ACC  = 16
) (
    input  logic             clock,
    input  logic             i_reset,
    input  logic             i_enable,
    input  logic             i_valid,
    input  logic [S_OUT-1:0] i_rc_filter,
    output logic             o_sync
);
    localparam int PW = $clog2(OS);
    localparam int SW = (N_ACC > 1) ? $clog2(N_ACC) : 1;
    localparam int AW = S_OUT + $clog2(N_ACC);

    if (TAPS < 1 || OS < 2 || (OS & (OS - 1)) != 0 || N_ACC < 1 || (N_ACC & (N_ACC - 1)) != 0) begin : g_bad_params
        $error("symbol_sync: unsupported parameter set");
    end

    logic [PW-1:0]    phase_cnt_q, phase_cnt_d;
    logic [SW-1:0]    sym_cnt_q, sym_cnt_d;
    logic [AW-1:0]    acc_q [OS];
    logic [AW-1:0]    acc_d [OS];
    logic [AW-1:0]    acc_sum [OS];
    logic [PW-1:0]    best_q, best_d;
    logic             o_sync_q, o_sync_d;
    logic             adv, phase_wrap, last;
    logic [S_OUT-1:0] mag;
    logic [AW-1:0]    max_val;
    logic [PW-1:0]    max_idx;

    // -2^(S_OUT-1) negates to itself, which read unsigned is exactly its magnitude
    assign mag = i_rc_filter[S_OUT-1] ? (~i_rc_filter + S_OUT'(1)) : i_rc_filter;

    always_comb begin
        adv        = i_enable & i_valid;
        phase_wrap = phase_cnt_q == PW'(OS - 1);
        last       = phase_wrap && sym_cnt_q == SW'(N_ACC - 1);
        max_val    = '0;
        max_idx    = '0;
        for (int p = 0; p < OS; p++) begin
            acc_sum[p] = acc_q[p] + ((PW'(p) == phase_cnt_q) ? AW'(mag) : AW'(0));
        end
        // strict compare keeps the lowest phase on ties
        for (int p = 0; p < OS; p++) begin
            if (acc_sum[p] > max_val) begin
                max_val = acc_sum[p];
                max_idx = PW'(p);
            end
        end
        for (int p = 0; p < OS; p++) begin
            acc_d[p] = adv ? (last ? '0 : acc_sum[p]) : acc_q[p];
        end
        phase_cnt_d = !adv ? phase_cnt_q : phase_wrap ? '0 : phase_cnt_q + PW'(1);
        sym_cnt_d   = !(adv && phase_wrap) ? sym_cnt_q :
                      (sym_cnt_q == SW'(N_ACC - 1)) ? '0 : sym_cnt_q + SW'(1);
        best_d      = (adv && last) ? max_idx : best_q;
        o_sync_d    = adv && phase_cnt_q == best_q;
    end

    always_ff @(posedge clock or posedge i_reset) begin
        if (i_reset) begin
            phase_cnt_q <= '0;
            sym_cnt_q   <= '0;
            best_q      <= '0;
            o_sync_q    <= 1'b0;
            for (int p = 0; p < OS; p++) acc_q[p] <= '0;
        end else begin
            phase_cnt_q <= phase_cnt_d;
            sym_cnt_q   <= sym_cnt_d;
            best_q      <= best_d;
            o_sync_q    <= o_sync_d;
            for (int p = 0; p < OS; p++) acc_q[p] <= acc_d[p];
        end
    end

    assign o_sync = o_sync_q;
endmodule

// File: tb/tb_symbol_sync.sv
// tb_symbol_sync: vector-table bench for symbol_sync (OS=4, N_ACC=16, S_OUT=10).
module tb_symbol_sync;
    logic       clock = 1'b0;
    logic       i_reset, i_enable, i_valid;
    logic [9:0] i_rc_filter;
    logic       o_sync;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [9:0] s;
        logic       v;
        logic       e;
        logic       exp_sync;
    } vec_t;

    vec_t vq[$];
    int   vec_id = 0;

    symbol_sync dut (
        .clock      (clock),
        .i_reset    (i_reset),
        .i_enable   (i_enable),
        .i_valid    (i_valid),
        .i_rc_filter(i_rc_filter),
        .o_sync     (o_sync)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s vec=%0d got=%b exp=%b", name, vec_id, got, exp);
        end
    endtask

    task automatic push(input int s, input logic v, input logic e, input logic exp_sync);
        vec_t r;
        r.s = 10'(s);
        r.v = v;
        r.e = e;
        r.exp_sync = exp_sync;
        vq.push_back(r);
    endtask

    // one window of n valid samples, amplitude a[k%4]; expected strobe at phase cur_best
    task automatic add_window(input int a0, input int a1, input int a2, input int a3,
                              input int cur_best, input int n);
        int a[4];
        a = '{a0, a1, a2, a3};
        for (int k = 0; k < n; k++) push(a[k % 4], 1'b1, 1'b1, (k % 4) == cur_best);
    endtask

    task automatic run_vecs(input string name);
        foreach (vq[i]) begin
            i_rc_filter = vq[i].s;
            i_valid     = vq[i].v;
            i_enable    = vq[i].e;
            @(posedge clock);
            @(negedge clock);
            check(name, o_sync, vq[i].exp_sync);
            vec_id++;
        end
        vq.delete();
    endtask

    initial begin
        i_reset = 1'b1;
        i_enable = 1'b1;
        i_valid = 1'b1;
        i_rc_filter = 10'h1ff;
        repeat (3) begin
            @(negedge clock);
            check("reset_hold", o_sync, 1'b0);
        end
        i_reset = 1'b0;

        // zeros: all tie, phase 0 stays chosen
        add_window(0, 0, 0, 0, 0, 64);
        // +200 at phase 2 -> best 2
        add_window(0, 0, 200, 0, 0, 64);
        // -300 at phase 3 beats +100 at phase 1 -> best 3
        add_window(0, 100, 0, -300, 2, 64);
        // -512 at phase 0 beats 511 at phase 1 -> best 0
        add_window(-512, 511, 0, 0, 3, 64);
        // tie 150 / -150 at phases 1 and 3 -> best 1
        add_window(0, 150, 0, -150, 0, 64);
        // 50 at phase 2 with two 3-cycle gaps; gap samples must not accumulate
        for (int k = 0; k < 64; k++) begin
            if (k == 20) repeat (3) push(-512, 1'b0, 1'b1, 1'b0);
            if (k == 40) repeat (3) push(-512, 1'b1, 1'b0, 1'b0);
            push((k % 4) == 2 ? 50 : 0, 1'b1, 1'b1, (k % 4) == 1);
        end
        // best 2 now in force; stop right after the phase-2 sample 30
        add_window(0, 0, 0, 0, 2, 31);
        run_vecs("sync");

        #1 i_reset = 1'b1;
        #1 check("reset_async", o_sync, 1'b0);
        i_rc_filter = 10'h200;
        @(posedge clock);
        @(negedge clock);
        check("reset_mid", o_sync, 1'b0);
        i_reset = 1'b0;

        // fresh window after reset: best back to 0, decides 1 after 64 samples
        add_window(0, 80, 0, 0, 0, 64);
        add_window(0, 0, 0, 0, 1, 8);
        run_vecs("post_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
